// File: rtl/morra_pkg.sv
// Shared types for the Morra Cinese game FSM and its scoreboard.
// Holds the round/match result encoding and the scoreboard FSM states.
package morra_pkg;

    // Raw 2-bit result as carried on MANCHE / PARTITA.
    typedef logic [1:0] esito_t;

    // Same encoding for round results (MANCHE) and match results (PARTITA).
    typedef enum logic [1:0] {
        NULLA   = 2'b00,
        PRIMO   = 2'b01,
        SECONDO = 2'b10,
        PARI    = 2'b11
    } esito_e;

    typedef enum logic [1:0] {
        ATTESA = 2'd0,
        GIOCO  = 2'd1,
        CHIUSA = 2'd2
    } stato_e;

    function automatic logic is_valido(esito_t e);
        return e != NULLA;
    endfunction

endpackage

// File: rtl/tabellone_morra_if.sv
// History read port of the scoreboard: valid/ready head, fill count, overflow.
// master = scoreboard (drives head/count/overflow), slave = display/host.
interface tabellone_morra_if #(
    parameter int HIST_DEPTH = 8
) ();
    import morra_pkg::*;

    localparam int CW = $clog2(HIST_DEPTH) + 1;

    logic          HIST_RD_VALID;
    logic          HIST_RD_READY;
    esito_t        HIST_RD_DATA;
    logic [CW-1:0] HIST_COUNT;
    logic          OVERFLOW;

    modport master (
        output HIST_RD_VALID,
        output HIST_RD_DATA,
        output HIST_COUNT,
        output OVERFLOW,
        input  HIST_RD_READY
    );

    modport slave (
        input  HIST_RD_VALID,
        input  HIST_RD_DATA,
        input  HIST_COUNT,
        input  OVERFLOW,
        output HIST_RD_READY
    );

endinterface

// File: rtl/tabellone_morra_storico_fifo.sv
// storico_fifo: synchronous FIFO of round results, no fall-through.
// Ports: push/push_data in; rd_valid/rd_ready/rd_data pop side; count, sticky overflow.
module storico_fifo
    import morra_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  esito_t                   push_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output esito_t                   rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    esito_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          pop;
    logic          do_push;
    logic          drop;

    assign full    = (count == CW'(DEPTH));
    assign pop     = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : NULLA;

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(pop);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tabellone_morra.sv
// Scoreboard behind MorraCinese: per-match round tallies, match tallies, FINE pulse.
// Ports: clk, rst, INIZIA, MANCHE, PARTITA, tallies, FINE, hist (history port).
// Optional history FIFO built only with `TABELLONE_HISTORY_EN defined.
module tabellone_morra
    import morra_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int MATCH_W    = 8,
    parameter int HIST_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               INIZIA,
    input  esito_t             MANCHE,
    input  esito_t             PARTITA,
    output logic [CNT_W-1:0]   VINTE_PRIMO,
    output logic [CNT_W-1:0]   VINTE_SECONDO,
    output logic [CNT_W-1:0]   PAREGGI,
    output logic [MATCH_W-1:0] PARTITE_PRIMO,
    output logic [MATCH_W-1:0] PARTITE_SECONDO,
    output logic               FINE,
    tabellone_morra_if.master  hist
);
    stato_e state_q;
    stato_e state_d;
    logic   clear;
    logic   tally;
    logic   close;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ATTESA;
        end else begin
            state_q <= state_d;
        end
    end

    // INIZIA overrides everything: restart without crediting the match.
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        tally   = 1'b0;
        close   = 1'b0;
        if (INIZIA) begin
            state_d = GIOCO;
            clear   = 1'b1;
        end else begin
            unique case (state_q)
                ATTESA: begin
                end
                GIOCO: begin
                    tally = is_valido(MANCHE);
                    if (is_valido(PARTITA)) begin
                        close   = 1'b1;
                        state_d = CHIUSA;
                    end
                end
                CHIUSA: begin
                end
                default: begin
                    state_d = ATTESA;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            VINTE_PRIMO     <= '0;
            VINTE_SECONDO   <= '0;
            PAREGGI         <= '0;
            PARTITE_PRIMO   <= '0;
            PARTITE_SECONDO <= '0;
            FINE            <= 1'b0;
        end else begin
            FINE <= close;
            if (clear) begin
                VINTE_PRIMO   <= '0;
                VINTE_SECONDO <= '0;
                PAREGGI       <= '0;
            end else if (tally) begin
                // Round counters saturate at all-ones.
                case (MANCHE)
                    PRIMO: begin
                        if (VINTE_PRIMO != '1) begin
                            VINTE_PRIMO <= VINTE_PRIMO + 1'b1;
                        end
                    end
                    SECONDO: begin
                        if (VINTE_SECONDO != '1) begin
                            VINTE_SECONDO <= VINTE_SECONDO + 1'b1;
                        end
                    end
                    PARI: begin
                        if (PAREGGI != '1) begin
                            PAREGGI <= PAREGGI + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            // Match counters wrap; a drawn match credits nobody.
            if (close) begin
                case (PARTITA)
                    PRIMO:   PARTITE_PRIMO   <= PARTITE_PRIMO + 1'b1;
                    SECONDO: PARTITE_SECONDO <= PARTITE_SECONDO + 1'b1;
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef TABELLONE_HISTORY_EN
    storico_fifo #(
        .DEPTH(HIST_DEPTH)
    ) u_storico (
        .clk       (clk),
        .rst       (rst),
        .push      (tally),
        .push_data (MANCHE),
        .rd_valid  (hist.HIST_RD_VALID),
        .rd_ready  (hist.HIST_RD_READY),
        .rd_data   (hist.HIST_RD_DATA),
        .count     (hist.HIST_COUNT),
        .overflow  (hist.OVERFLOW)
    );
`else
    logic unused_rd_ready;
    assign unused_rd_ready    = hist.HIST_RD_READY;
    assign hist.HIST_RD_VALID = 1'b0;
    assign hist.HIST_RD_DATA  = NULLA;
    assign hist.HIST_COUNT    = '0;
    assign hist.OVERFLOW      = 1'b0;
`endif

endmodule

// File: tb/tb_tabellone_morra.sv
// Self-checking bench for tabellone_morra: directed scenarios then random play.
// Reference model tracks tallies with integers and history with a queue.
module tb_tabellone_morra;
    import morra_pkg::*;

    localparam int CNT_W   = 4;
    localparam int MATCH_W = 8;
    localparam int DEPTH   = 8;
    localparam int SAT     = (1 << CNT_W) - 1;
    localparam int MMOD    = 1 << MATCH_W;
`ifdef TABELLONE_HISTORY_EN
    localparam bit HEN = 1'b1;
`else
    localparam bit HEN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               INIZIA;
    esito_t             MANCHE;
    esito_t             PARTITA;
    logic [CNT_W-1:0]   vp, vs, pa;
    logic [MATCH_W-1:0] pp, ps;
    logic               fine;

    tabellone_morra_if #(.HIST_DEPTH(DEPTH)) hist ();

    tabellone_morra #(
        .CNT_W(CNT_W), .MATCH_W(MATCH_W), .HIST_DEPTH(DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .INIZIA          (INIZIA),
        .MANCHE          (MANCHE),
        .PARTITA         (PARTITA),
        .VINTE_PRIMO     (vp),
        .VINTE_SECONDO   (vs),
        .PAREGGI         (pa),
        .PARTITE_PRIMO   (pp),
        .PARTITE_SECONDO (ps),
        .FINE            (fine),
        .hist            (hist.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int m_vp, m_vs, m_pa, m_pp, m_ps;
    bit m_fine, m_play, m_ovf;
    int q[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(bit r, bit i, int m, int p, bit rdy);
        bit pop;
        bit push;
        if (r) begin
            m_vp = 0; m_vs = 0; m_pa = 0; m_pp = 0; m_ps = 0;
            m_fine = 0; m_play = 0; m_ovf = 0;
            q.delete();
        end else begin
            pop    = HEN && (q.size() > 0) && rdy;
            push   = 1'b0;
            m_fine = 0;
            if (i) begin
                m_vp = 0; m_vs = 0; m_pa = 0;
                m_play = 1;
            end else if (m_play) begin
                if (m != 0) begin
                    push = HEN;
                    if (m == 1) m_vp = (m_vp < SAT) ? m_vp + 1 : SAT;
                    if (m == 2) m_vs = (m_vs < SAT) ? m_vs + 1 : SAT;
                    if (m == 3) m_pa = (m_pa < SAT) ? m_pa + 1 : SAT;
                end
                if (p != 0) begin
                    if (p == 1) m_pp = (m_pp + 1) % MMOD;
                    if (p == 2) m_ps = (m_ps + 1) % MMOD;
                    m_fine = 1;
                    m_play = 0;
                end
            end
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back(m);
                else m_ovf = 1;
            end
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".vp"}, 32'(vp), 32'(m_vp));
        chk({tag, ".vs"}, 32'(vs), 32'(m_vs));
        chk({tag, ".pa"}, 32'(pa), 32'(m_pa));
        chk({tag, ".pp"}, 32'(pp), 32'(m_pp));
        chk({tag, ".ps"}, 32'(ps), 32'(m_ps));
        chk({tag, ".fine"}, 32'(fine), 32'(m_fine));
        chk({tag, ".valid"}, 32'(hist.HIST_RD_VALID), 32'(q.size() > 0));
        chk({tag, ".data"}, 32'(hist.HIST_RD_DATA),
            (q.size() > 0) ? 32'(q[0]) : 32'd0);
        chk({tag, ".count"}, 32'(hist.HIST_COUNT), 32'(q.size()));
        chk({tag, ".ovf"}, 32'(hist.OVERFLOW), 32'(m_ovf));
    endtask

    task automatic step(string tag, bit r, bit i, int m, int p, bit rdy);
        rst    = r;
        INIZIA = i;
        MANCHE = esito_t'(m);
        PARTITA = esito_t'(p);
        hist.HIST_RD_READY = rdy;
        @(posedge clk);
        model_edge(r, i, m, p, rdy);
        #1;
        check_all(tag);
    endtask

    initial begin
        int seq[4];
        seq = '{1, 2, 1, 3};

        // Reset state.
        step("reset", 1, 0, 0, 0, 0);
        step("reset2", 1, 0, 3, 1, 1);
        chk("reset.vp0", 32'(vp), 32'd0);

        // Ignored in ATTESA.
        step("attesa", 0, 0, 1, 1, 0);

        // Basic tally.
        step("b.start", 0, 1, 0, 0, 0);
        foreach (seq[k]) step("b.round", 0, 0, seq[k], 0, 0);
        chk("basic.vp", 32'(vp), 32'd2);
        chk("basic.vs", 32'(vs), 32'd1);
        chk("basic.pa", 32'(pa), 32'd1);
        chk("basic.count", 32'(hist.HIST_COUNT), HEN ? 32'd4 : 32'd0);
        for (int k = 0; k < 5; k++) step("b.drain", 0, 0, 0, 0, 1);

        // Match end in the same cycle as the final round.
        step("end.final", 0, 0, 1, 1, 0);
        chk("end.fine", 32'(fine), 32'd1);
        chk("end.pp", 32'(pp), 32'd1);
        step("end.idle", 0, 0, 0, 0, 0);
        chk("end.fine_drop", 32'(fine), 32'd0);
        step("end.chiusa", 0, 0, 2, 2, 0);
        chk("end.vs_hold", 32'(vs), 32'd1);

        // Abandon mid-match with a coincident PARTITA.
        step("ab.start", 0, 1, 0, 0, 1);
        step("ab.r1", 0, 0, 2, 0, 1);
        step("ab.r2", 0, 0, 3, 0, 1);
        step("ab.inizia", 0, 1, 2, 2, 1);
        chk("ab.ps", 32'(ps), 32'd0);
        chk("ab.vs0", 32'(vs), 32'd0);
        step("ab.after", 0, 0, 0, 0, 1);
        chk("ab.fine", 32'(fine), 32'd0);
        step("ab.gioco", 0, 0, 1, 0, 1);
        chk("ab.in_gioco", 32'(vp), 32'd1);

        // Saturation.
        step("sat.start", 0, 1, 0, 0, 1);
        for (int k = 0; k < 17; k++) step("sat.r", 0, 0, 2, 0, 1);
        chk("sat.vs", 32'(vs), 32'd15);

        // Overflow.
        for (int k = 0; k < 3; k++) step("ov.drain", 0, 0, 0, 0, 1);
        step("ov.start", 0, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) step("ov.push", 0, 0, (k % 3) + 1, 0, 0);
        step("ov.ninth", 0, 0, 2, 0, 0);
        chk("ov.count", 32'(hist.HIST_COUNT), HEN ? 32'd8 : 32'd0);
        chk("ov.flag", 32'(hist.OVERFLOW), 32'(HEN));
        step("ov.pushpop", 0, 0, 3, 0, 1);
        chk("ov.count_keep", 32'(hist.HIST_COUNT), HEN ? 32'd8 : 32'd0);
        for (int k = 0; k < 9; k++) step("ov.drain2", 0, 0, 0, 0, 1);

        // Reset mid-drain.
        step("rd.start", 0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) step("rd.push", 0, 0, 3 - (k % 3), 0, 0);
        step("rd.pop", 0, 0, 0, 0, 1);
        step("rd.push6", 0, 0, 1, 0, 0);
        step("rd.rst", 1, 0, 1, 0, 1);
        chk("rd.count0", 32'(hist.HIST_COUNT), 32'd0);
        chk("rd.valid0", 32'(hist.HIST_RD_VALID), 32'd0);

        // Random play.
        for (int k = 0; k < 600; k++) begin
            bit r, i, rdy;
            int m, p;
            r   = ($urandom % 60) == 0;
            i   = ($urandom % 12) == 0;
            m   = $urandom % 4;
            p   = (($urandom % 8) == 0) ? int'($urandom % 4) : 0;
            rdy = ($urandom % 3) != 0;
            step("rand", r, i, m, p, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
